// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller: issues word/byte loads and stores on a req/ack
// data-memory port, stalls the pipeline while busy and returns aligned load data.
module mem_stage_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memReadIn,
   input  logic        memWriteIn,
   input  logic        loadFullWordIn,
   input  logic        loadSignedIn,
   input  logic [31:0] aluResultIn,
   input  logic [31:0] regData2In,
   output logic        dmemReq,
   output logic        dmemWe,
   output logic [31:0] dmemAddr,
   output logic [31:0] dmemWData,
   output logic [3:0]  dmemByteEn,
   input  logic [31:0] dmemRData,
   input  logic        dmemAck,
   output logic        stall,
   output logic [31:0] loadDataOut,
   output logic        accessErr,
   output logic        busErr
);

   localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               ld_pend;
   logic               ld_full;
   logic               ld_sgn;
   logic [1:0]         ld_off;

   logic               access_c;
   logic               bad_c;
   logic [7:0]         rbyte_c;
   logic [31:0]        load_val_c;

   assign access_c = memReadIn ^ memWriteIn;
   assign bad_c    = (memReadIn & memWriteIn) | (loadFullWordIn & (aluResultIn[1:0] != 2'b00));

   // Gated by reset so an abandoned transaction releases the pipeline at once.
   assign stall = reset & (((state == IDLE) & access_c & ~bad_c) | (state == ACCESS));

   // Little-endian byte select and extension of the returned word.
   always_comb begin
      rbyte_c = dmemRData[7:0];
      case (ld_off)
         2'd0:    rbyte_c = dmemRData[7:0];
         2'd1:    rbyte_c = dmemRData[15:8];
         2'd2:    rbyte_c = dmemRData[23:16];
         default: rbyte_c = dmemRData[31:24];
      endcase
      if (ld_full)
         load_val_c = dmemRData;
      else if (ld_sgn)
         load_val_c = {{24{rbyte_c[7]}}, rbyte_c};
      else
         load_val_c = {24'h000000, rbyte_c};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         ld_pend     <= 1'b0;
         ld_full     <= 1'b0;
         ld_sgn      <= 1'b0;
         ld_off      <= 2'b00;
         dmemReq     <= 1'b0;
         dmemWe      <= 1'b0;
         dmemAddr    <= 32'h0;
         dmemWData   <= 32'h0;
         dmemByteEn  <= 4'h0;
         loadDataOut <= 32'h0;
         accessErr   <= 1'b0;
         busErr      <= 1'b0;
      end else begin
         accessErr <= 1'b0;
         busErr    <= 1'b0;
         case (state)
            IDLE: begin
               if (bad_c) begin
                  accessErr <= 1'b1;
               end else if (access_c) begin
                  state    <= ACCESS;
                  cnt      <= '0;
                  dmemReq  <= 1'b1;
                  dmemWe   <= memWriteIn;
                  dmemAddr <= {aluResultIn[31:2], 2'b00};
                  ld_pend  <= memReadIn;
                  ld_full  <= loadFullWordIn;
                  ld_sgn   <= loadSignedIn;
                  ld_off   <= aluResultIn[1:0];
                  if (memWriteIn && !loadFullWordIn) begin
                     dmemWData  <= {4{regData2In[7:0]}};
                     dmemByteEn <= 4'b0001 << aluResultIn[1:0];
                  end else begin
                     dmemWData  <= regData2In;
                     dmemByteEn <= 4'b1111;
                  end
               end
            end
            ACCESS: begin
               if (dmemAck) begin
                  if (ld_pend)
                     loadDataOut <= load_val_c;
                  dmemReq <= 1'b0;
                  state   <= DONE;
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  dmemReq <= 1'b0;
                  busErr  <= 1'b1;
                  state   <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: transaction-level reference model,
// per-cycle compare process, directed cases with literal expectations, random traffic.
module tb_mem_stage_ctrl;

   localparam int unsigned TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        memReadIn, memWriteIn, loadFullWordIn, loadSignedIn;
   logic [31:0] aluResultIn, regData2In;
   logic        dmemReq, dmemWe;
   logic [31:0] dmemAddr, dmemWData;
   logic [3:0]  dmemByteEn;
   logic [31:0] dmemRData;
   logic        dmemAck;
   logic        stall;
   logic [31:0] loadDataOut;
   logic        accessErr, busErr;

   mem_stage_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .memReadIn(memReadIn), .memWriteIn(memWriteIn),
      .loadFullWordIn(loadFullWordIn), .loadSignedIn(loadSignedIn),
      .aluResultIn(aluResultIn), .regData2In(regData2In),
      .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr),
      .dmemWData(dmemWData), .dmemByteEn(dmemByteEn),
      .dmemRData(dmemRData), .dmemAck(dmemAck),
      .stall(stall), .loadDataOut(loadDataOut),
      .accessErr(accessErr), .busErr(busErr)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   bit          chk_en   = 1'b0;
   logic        exp_stall, exp_req, exp_we, exp_aerr, exp_berr;
   logic [31:0] exp_addr, exp_wdata, exp_ld;
   logic [3:0]  exp_be;
   logic [31:0] model_ld;
   logic        pend_aerr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model's expectations.
   always @(negedge clk) begin
      if (chk_en) begin
         check("stall", 32'(stall), 32'(exp_stall));
         check("dmemReq", 32'(dmemReq), 32'(exp_req));
         check("accessErr", 32'(accessErr), 32'(exp_aerr));
         check("busErr", 32'(busErr), 32'(exp_berr));
         check("loadDataOut", loadDataOut, exp_ld);
         if (exp_req) begin
            check("dmemAddr", dmemAddr, exp_addr);
            check("dmemWe", 32'(dmemWe), 32'(exp_we));
            check("dmemByteEn", 32'(dmemByteEn), 32'(exp_be));
            if (exp_we) check("dmemWData", dmemWData, exp_wdata);
         end
      end
   end

   function automatic logic [31:0] load_model(input logic full, input logic sgn,
                                              input logic [1:0] off, input logic [31:0] rdata);
      logic [7:0] b;
      b = 8'(rdata >> (8 * off));
      if (full) return rdata;
      return sgn ? 32'($signed(b)) : 32'(b);
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // One EXE/MEM instruction; ack_cyc = ACCESS cycle carrying the ack (0 = never).
   task automatic run_instr(input logic rd, input logic wr, input logic full, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] data,
                            input int ack_cyc, input logic [31:0] ack_data,
                            output int n_stall, output logic [31:0] seen_addr,
                            output logic [3:0] seen_be, output logic [31:0] seen_wdata);
      logic access, bad, timed_out;
      access = rd ^ wr;
      bad    = (rd & wr) | (full & (addr[1:0] != 2'b00));
      seen_addr = 32'hx; seen_be = 4'hx; seen_wdata = 32'hx;
      next_cycle();
      memReadIn = rd; memWriteIn = wr; loadFullWordIn = full; loadSignedIn = sgn;
      aluResultIn = addr; regData2In = data;
      dmemAck = 1'($urandom_range(0, 1));
      dmemRData = $urandom;
      exp_stall = access & ~bad; exp_req = 1'b0; exp_aerr = pend_aerr; exp_berr = 1'b0;
      exp_ld = model_ld;
      pend_aerr = bad;
      n_stall = exp_stall ? 1 : 0;
      chk_en = 1'b1;
      if (access && !bad) begin
         timed_out = 1'b1;
         exp_addr  = {addr[31:2], 2'b00};
         exp_we    = wr;
         exp_be    = (wr && !full) ? 4'(1 << addr[1:0]) : 4'hf;
         exp_wdata = full ? data : {4{data[7:0]}};
         for (int k = 1; k <= int'(TIMEOUT); k++) begin
            next_cycle();
            dmemAck   = (k == ack_cyc);
            dmemRData = dmemAck ? ack_data : $urandom;
            exp_req = 1'b1; exp_stall = 1'b1; exp_aerr = 1'b0;
            n_stall++;
            if (k == 1) begin
               seen_addr = dmemAddr; seen_be = dmemByteEn; seen_wdata = dmemWData;
            end
            if (dmemAck) begin
               timed_out = 1'b0;
               if (rd) model_ld = load_model(full, sgn, addr[1:0], ack_data);
               break;
            end
         end
         next_cycle();
         dmemAck   = 1'($urandom_range(0, 1));
         dmemRData = $urandom;
         exp_req = 1'b0; exp_stall = 1'b0; exp_berr = timed_out; exp_ld = model_ld;
      end
   endtask

   int          ns;
   logic [31:0] sa, sw;
   logic [3:0]  sb;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      memReadIn = 0; memWriteIn = 0; loadFullWordIn = 0; loadSignedIn = 0;
      aluResultIn = 0; regData2In = 0; dmemRData = 0; dmemAck = 0;
      model_ld = 32'h0; pend_aerr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_dmemReq", 32'(dmemReq), 32'h0);
      check("rst_dmemWe", 32'(dmemWe), 32'h0);
      check("rst_dmemAddr", dmemAddr, 32'h0);
      check("rst_dmemWData", dmemWData, 32'h0);
      check("rst_dmemByteEn", 32'(dmemByteEn), 32'h0);
      check("rst_loadDataOut", loadDataOut, 32'h0);
      check("rst_errs", 32'({accessErr, busErr}), 32'h0);
      check("rst_stall", 32'(stall), 32'h0);
      reset = 1'b1;

      // Word load, ack in first ACCESS cycle.
      run_instr(1, 0, 1, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF, ns, sa, sb, sw);
      check("wl_data", loadDataOut, 32'hDEADBEEF);
      check("wl_addr", sa, 32'h10);
      check("wl_stall_cycles", 32'(ns), 32'd2);

      // Byte loads.
      run_instr(1, 0, 0, 1, 32'h13, 32'h0, 2, 32'h80112233, ns, sa, sb, sw);
      check("bl_signed", loadDataOut, 32'hFFFFFF80);
      run_instr(1, 0, 0, 0, 32'h13, 32'h0, 1, 32'h80112233, ns, sa, sb, sw);
      check("bl_unsigned", loadDataOut, 32'h00000080);
      run_instr(1, 0, 0, 1, 32'h11, 32'h0, 1, 32'h80112233, ns, sa, sb, sw);
      check("bl_off1", loadDataOut, 32'h00000022);

      // Byte store, ack after three ACCESS cycles.
      run_instr(0, 1, 0, 0, 32'h22, 32'hA5, 3, 32'h0, ns, sa, sb, sw);
      check("bs_addr", sa, 32'h20);
      check("bs_be", 32'(sb), 32'h4);
      check("bs_wdata", sw, 32'hA5A5A5A5);
      check("bs_ld_held", loadDataOut, 32'h00000022);
      check("bs_stall_cycles", 32'(ns), 32'd4);

      // Misaligned word load and read+write conflict.
      run_instr(1, 0, 1, 0, 32'h6, 32'h0, 1, 32'h0, ns, sa, sb, sw);
      check("mis_stall", 32'(ns), 32'd0);
      run_instr(0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0, ns, sa, sb, sw);
      check("mis_aerr", 32'(accessErr), 32'h1);
      run_instr(1, 1, 0, 0, 32'h40, 32'h0, 1, 32'h0, ns, sa, sb, sw);
      run_instr(0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0, ns, sa, sb, sw);
      check("rw_aerr", 32'(accessErr), 32'h1);

      // Ack never arrives.
      run_instr(1, 0, 1, 0, 32'h100, 32'h0, 0, 32'h0, ns, sa, sb, sw);
      check("to_busErr", 32'(busErr), 32'h1);
      check("to_ld_held", loadDataOut, 32'h00000022);
      check("to_stall_cycles", 32'(ns), 32'(TIMEOUT + 1));

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         int          sel, ack_cyc;
         logic        rd, wr, full;
         logic [31:0] addr;
         sel = int'($urandom_range(0, 7));
         rd = (sel == 1) || (sel >= 2 && sel <= 4);
         wr = (sel == 1) || (sel >= 5);
         full = 1'($urandom_range(0, 1));
         addr = $urandom;
         if (full && $urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
         ack_cyc = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 5));
         run_instr(rd, wr, full, 1'($urandom_range(0, 1)), addr, $urandom,
                   ack_cyc, $urandom, ns, sa, sb, sw);
      end

      // Reset in the middle of an access.
      next_cycle();
      memReadIn = 1; memWriteIn = 0; loadFullWordIn = 1; aluResultIn = 32'h40; dmemAck = 0;
      exp_stall = 1; exp_req = 0; exp_aerr = pend_aerr; exp_berr = 0; exp_ld = model_ld;
      pend_aerr = 0;
      exp_addr = 32'h40; exp_we = 0; exp_be = 4'hf;
      repeat (2) begin
         next_cycle();
         exp_req = 1; exp_aerr = 0;
      end
      #2;
      chk_en = 1'b0;
      reset = 1'b0;
      #1;
      check("mid_rst_req", 32'(dmemReq), 32'h0);
      check("mid_rst_stall", 32'(stall), 32'h0);
      check("mid_rst_ld", loadDataOut, 32'h0);
      model_ld = 32'h0;
      repeat (2) next_cycle();
      memReadIn = 0; memWriteIn = 0; loadFullWordIn = 0;
      reset = 1'b1;
      dmemAck = 1'b1; dmemRData = 32'h12345678;
      exp_stall = 0; exp_req = 0; exp_aerr = 0; exp_berr = 0; exp_ld = 32'h0;
      chk_en = 1'b1;
      repeat (3) next_cycle();
      check("late_ack_ld", loadDataOut, 32'h0);
      check("late_ack_req", 32'(dmemReq), 32'h0);
      dmemAck = 1'b0;
      chk_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
